ofdm_result_uart: RTL and testbench

- Downstream consumer of the OFDM demodulator's decoded result.
- Waits for the demodulator's finish flag and latches the 96-bit payload and the success flag.
- Pulses clear back to the demodulator, then serialises a framed report over UART (8N1) to the host.
- Provides backpressure: the demodulator's finish stays high until this block accepts it, so no result is lost.

---
 rtl/ofdm_result_uart.sv | 154 +++++++++++++++
 tb/tb_ofdm_result_uart.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_result_uart.sv
// Accepts one demodulator result, acknowledges it with a clear pulse and sends
// it to the host as an 8N1 UART frame: HEADER, STATUS, [12 data bytes], CHK.
module ofdm_result_uart #(
    parameter int          CLKS_PER_BIT = 234,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        finish,
    input  logic        success,
    input  logic [95:0] res,
    output logic        clear,
    output logic        tx,
    output logic        busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_OK   = 4'd14;
    localparam logic [3:0]        LAST_FAIL = 4'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  baud_reg;
    logic [2:0]        bit_reg;
    logic [3:0]        idx_reg;
    logic [95:0]       res_reg;
    logic              success_reg;
    logic [7:0]        chk_reg;
    logic              clear_reg;
    logic              busy_reg;

    logic [7:0]        data_bytes [12];
    logic [7:0]        status_byte;
    logic [7:0]        cur_byte;
    logic [7:0]        next_byte;
    logic [3:0]        idx_last;
    logic [3:0]        idx_inc;
    logic [3:0]        cur_sel;
    logic [3:0]        nxt_sel;
    logic              baud_done;
    logic              last_byte;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_bytes
            assign data_bytes[gi] = res_reg[95 - 8*gi -: 8];
        end
    endgenerate

    assign status_byte = {7'd0, success_reg};
    assign baud_done   = (baud_reg == BAUD_LAST);
    assign idx_last    = success_reg ? LAST_OK : LAST_FAIL;
    assign last_byte   = (idx_reg == idx_last);
    assign idx_inc     = idx_reg + 4'd1;
    assign cur_sel     = idx_reg - 4'd2;
    assign nxt_sel     = idx_reg - 4'd1;
    assign accept      = (state_reg == IDLE) && finish && !clear_reg;

    // Byte on the wire comes only from the latched copy, so res may change freely.
    always_comb begin
        cur_byte = data_bytes[cur_sel];
        if (idx_reg == 4'd0)
            cur_byte = HEADER;
        else if (idx_reg == 4'd1)
            cur_byte = status_byte;
        else if (last_byte)
            cur_byte = chk_reg;
    end

    always_comb begin
        next_byte = data_bytes[nxt_sel];
        if (idx_inc == 4'd1)
            next_byte = status_byte;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = START;
            START: if (baud_done) state_next = DATA;
            DATA:  if (baud_done && bit_reg == 3'd7) state_next = STOP;
            STOP:  if (baud_done) state_next = last_byte ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx = 1'b1;
        case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_reg];
            default: tx = 1'b1;
        endcase
        clear = clear_reg;
        busy  = busy_reg;
    end

    // Datapath: baud/bit/byte counters, result latch and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_reg    <= '0;
            bit_reg     <= '0;
            idx_reg     <= '0;
            res_reg     <= '0;
            success_reg <= 1'b0;
            chk_reg     <= '0;
            clear_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            clear_reg <= accept;
            if (state_reg == IDLE) begin
                baud_reg <= '0;
                bit_reg  <= '0;
                if (accept) begin
                    res_reg     <= res;
                    success_reg <= success;
                    chk_reg     <= '0;
                    idx_reg     <= '0;
                    busy_reg    <= 1'b1;
                end
            end else begin
                baud_reg <= baud_done ? '0 : baud_reg + CNT_W'(1);
                if (state_reg == START && baud_done)
                    bit_reg <= '0;
                if (state_reg == DATA && baud_done)
                    bit_reg <= bit_reg + 3'd1;
                if (state_reg == STOP && baud_done) begin
                    if (last_byte) begin
                        busy_reg <= 1'b0;
                    end else begin
                        idx_reg <= idx_inc;
                        // The checksum byte itself is not folded into the checksum.
                        if (idx_inc != idx_last)
                            chk_reg <= chk_reg ^ next_byte;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ofdm_result_uart.sv
// Bench for ofdm_result_uart: frame-level bitstream model checked every cycle,
// a UART receiver for byte-level literal checks, and a slow-baud timing check.
module tb_ofdm_result_uart;

    localparam int CPB_F = 4;
    localparam int CPB_S = 234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        finish = 1'b0;
    logic        finish_slow = 1'b0;
    logic        success = 1'b0;
    logic [95:0] res = '0;
    logic        clear_f, tx_f, busy_f;
    logic        clear_s, tx_s, busy_s;

    always #5 clk = ~clk;

    ofdm_result_uart #(.CLKS_PER_BIT(CPB_F), .HEADER(8'hAA)) dut (
        .clk(clk), .rst_n(rst_n), .finish(finish), .success(success), .res(res),
        .clear(clear_f), .tx(tx_f), .busy(busy_f)
    );

    ofdm_result_uart #(.CLKS_PER_BIT(CPB_S), .HEADER(8'hAA)) dut_slow (
        .clk(clk), .rst_n(rst_n), .finish(finish_slow), .success(success), .res(res),
        .clear(clear_s), .tx(tx_s), .busy(busy_s)
    );

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    // Behavioural model: a frame is a bitstream, each bit lasting cpb cycles.
    bit   m_bits [2][150];
    int   m_rem  [2] = '{0, 0};
    int   m_pos  [2] = '{0, 0};
    bit   m_clr  [2] = '{0, 0};
    int   m_cpb  [2] = '{CPB_F, CPB_S};
    logic [7:0] exp_q [$];

    // UART receiver and monitors
    logic [7:0] rx_q [$];
    logic [7:0] want_q [$];
    logic [7:0] rx_b;
    bit   rx_ok, rx_stop;
    int   rx_frame_err = 0;
    int   busy_cnt = 0, clear_cnt = 0, busy_s_cnt = 0;
    bit   slow_act = 0, slow_prev = 1;
    longint t0 = 0;
    int   slow_edges = 0, slow_bad = 0;

    logic [7:0] lit_ok [15] = '{8'hAA, 8'h01, 8'h55, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h11, 8'h55, 8'h10};

    function automatic int make_frame(input logic [95:0] r, input logic s,
                                      output logic [7:0] b [15]);
        int n;
        logic [7:0] chk;
        for (int k = 0; k < 15; k++) b[k] = 8'h00;
        b[0] = 8'hAA;
        b[1] = s ? 8'h01 : 8'h00;
        chk  = b[1];
        n    = s ? 15 : 3;
        if (s) begin
            for (int k = 0; k < 12; k++) begin
                b[2+k] = r[95 - 8*k -: 8];
                chk    = chk ^ b[2+k];
            end
        end
        b[n-1] = chk;
        return n;
    endfunction

    initial begin
        logic [7:0] fb [15];
        int n;
        bit fin;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                fin = (i == 0) ? finish : finish_slow;
                if (!rst_n) begin
                    m_rem[i] = 0; m_pos[i] = 0; m_clr[i] = 0;
                end else if (m_rem[i] == 0 && fin) begin
                    n = make_frame(res, success, fb);
                    for (int k = 0; k < n; k++) begin
                        m_bits[i][k*10] = 1'b0;
                        for (int j = 0; j < 8; j++) m_bits[i][k*10+1+j] = fb[k][j];
                        m_bits[i][k*10+9] = 1'b1;
                        if (i == 0) exp_q.push_back(fb[k]);
                    end
                    m_rem[i] = n * 10 * m_cpb[i];
                    m_pos[i] = 0;
                    m_clr[i] = 1;
                end else begin
                    m_clr[i] = 0;
                    if (m_rem[i] > 0) begin
                        m_rem[i]--;
                        m_pos[i]++;
                    end
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model, plus monitors
    initial begin
        logic [2:0] got_v, exp_v;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                got_v = (i == 0) ? {tx_f, busy_f, clear_f} : {tx_s, busy_s, clear_s};
                exp_v[2] = (m_rem[i] > 0) ? m_bits[i][m_pos[i] / m_cpb[i]] : 1'b1;
                exp_v[1] = (m_rem[i] > 0);
                exp_v[0] = m_clr[i];
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL cycle_cmp dut%0d cyc=%0d tx/busy/clear got=%b required=%b",
                             i, cyc, got_v, exp_v);
                end
            end
            if (busy_f) busy_cnt++;
            if (clear_f) clear_cnt++;
            if (busy_s) busy_s_cnt++;
            if (!rst_n) begin
                slow_act = 0;
            end else if (!slow_act) begin
                if (busy_s && !tx_s) begin
                    slow_act = 1;
                    t0 = cyc;
                end
            end else begin
                if (tx_s != slow_prev) begin
                    slow_edges++;
                    if ((cyc - t0) % CPB_S != 0) slow_bad++;
                end
                if (!busy_s) slow_act = 0;
            end
            slow_prev = tx_s;
        end
    end

    // UART receiver for the fast instance, sampling mid-bit
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !tx_f) begin
                rx_ok = 1; rx_b = 8'h00; rx_stop = 0;
                for (int k = 1; k <= 9*CPB_F + CPB_F/2; k++) begin
                    @(negedge clk);
                    if (!rst_n) rx_ok = 0;
                    if (k % CPB_F == CPB_F/2) begin
                        if (k / CPB_F >= 1 && k / CPB_F <= 8) rx_b[k/CPB_F - 1] = tx_f;
                        else if (k / CPB_F == 9) rx_stop = tx_f;
                    end
                end
                if (rx_ok) begin
                    if (!rx_stop) rx_frame_err++;
                    rx_q.push_back(rx_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic check_rx(input string name);
        checks++;
        if (rx_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL %s byte_count got=%0d required=%0d", name, rx_q.size(), want_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < want_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== want_q[k]) begin
                failures++;
                $display("FAIL %s byte%0d got=%h required=%h", name, k, rx_q[k], want_q[k]);
            end
        end
        check_eq({name, "_framing"}, rx_frame_err, 0);
    endtask

    task automatic wait_fast_idle(input int maxc, input string name);
        int n = 0;
        while (busy_f && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (busy_f) begin
            failures++;
            $display("FAIL %s timeout busy got=1 required=0 after %0d cycles", name, maxc);
        end
    endtask

    task automatic push_ok_frame();
        for (int k = 0; k < 15; k++) want_q.push_back(lit_ok[k]);
    endtask

    initial begin
        int bad, n;
        int hold;
        #1 rst_n = 1'b0;
        repeat (5) tick();
        check_eq("rst_tx", tx_f, 1);
        check_eq("rst_busy", busy_f, 0);
        check_eq("rst_clear", clear_f, 0);

        // Idle after reset release
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (tx_f !== 1'b1 || busy_f !== 1'b0 || clear_f !== 1'b0) bad++;
        end
        check_eq("idle100_bad_cycles", bad, 0);

        // Success frame
        rx_q.delete(); want_q.delete(); rx_frame_err = 0;
        busy_cnt = 0; clear_cnt = 0;
        res = 96'h55_0123456789ABCDEF0011_55; success = 1'b1; finish = 1'b1;
        tick();
        check_eq("accept_clear", clear_f, 1);
        check_eq("accept_tx_start", tx_f, 0);
        finish = 1'b0;
        tick();
        check_eq("clear_one_cycle", clear_f, 0);
        wait_fast_idle(700, "ok_frame");
        tick();
        check_eq("ok_busy_cycles", busy_cnt, 600);
        check_eq("ok_clear_pulses", clear_cnt, 1);
        push_ok_frame();
        check_rx("ok_bytes");

        // Fail frame
        rx_q.delete(); want_q.delete(); rx_frame_err = 0;
        busy_cnt = 0; clear_cnt = 0;
        res = {$urandom, $urandom, $urandom}; success = 1'b0; finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_fast_idle(300, "fail_frame");
        tick();
        check_eq("fail_busy_cycles", busy_cnt, 120);
        check_eq("fail_clear_pulses", clear_cnt, 1);
        want_q.push_back(8'hAA); want_q.push_back(8'h00); want_q.push_back(8'h00);
        check_rx("fail_bytes");

        // Backpressure: second result held while the first frame is on the wire
        rx_q.delete(); want_q.delete(); rx_frame_err = 0;
        busy_cnt = 0; clear_cnt = 0;
        res = 96'h55_0123456789ABCDEF0011_55; success = 1'b1; finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (49) tick();
        res = {12{8'h55}}; success = 1'b1; finish = 1'b1;
        wait_fast_idle(700, "bp_first");
        n = 0;
        while (!clear_f && n < 10) begin
            tick();
            n++;
        end
        check_eq("bp_clear_gap", n, 1);
        check_eq("bp_busy_again", busy_f, 1);
        finish = 1'b0;
        wait_fast_idle(700, "bp_second");
        tick();
        check_eq("bp_busy_cycles", busy_cnt, 1200);
        check_eq("bp_clear_pulses", clear_cnt, 2);
        push_ok_frame();
        want_q.push_back(8'hAA); want_q.push_back(8'h01);
        repeat (12) want_q.push_back(8'h55);
        want_q.push_back(8'h01);
        check_rx("bp_bytes");

        // Reset in the middle of byte 5 data bits
        res = 96'h55_0123456789ABCDEF0011_55; success = 1'b1; finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (210) tick();
        check_eq("mid_busy_before", busy_f, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_async_tx", tx_f, 1);
        check_eq("mid_async_busy", busy_f, 0);
        check_eq("mid_async_clear", clear_f, 0);
        repeat (60) tick();
        rx_q.delete(); want_q.delete(); rx_frame_err = 0;
        busy_cnt = 0; clear_cnt = 0;
        rst_n = 1'b1; finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_fast_idle(700, "mid_restart");
        tick();
        check_eq("mid_busy_cycles", busy_cnt, 600);
        push_ok_frame();
        check_rx("mid_bytes");

        // Randomized results, hold times and late res changes
        for (int it = 0; it < 8; it++) begin
            rx_q.delete(); exp_q.delete(); rx_frame_err = 0;
            res = {$urandom, $urandom, $urandom};
            success = 1'($urandom_range(0, 1));
            finish = 1'b1;
            hold = $urandom_range(1, 200);
            repeat (hold) begin
                tick();
                if ($urandom_range(0, 9) == 0) res = {$urandom, $urandom, $urandom};
            end
            finish = 1'b0;
            tick();
            wait_fast_idle(2000, "rand_frame");
            tick();
            want_q = exp_q;
            check_rx("rand_bytes");
        end

        // Slow baud rate: every line edge lands on a bit boundary
        busy_s_cnt = 0; slow_edges = 0; slow_bad = 0;
        success = 1'b0; res = {$urandom, $urandom, $urandom}; finish_slow = 1'b1;
        tick();
        finish_slow = 1'b0;
        n = 0;
        while (busy_s && n < 8000) begin
            tick();
            n++;
        end
        check_eq("slow_timeout_busy", busy_s, 0);
        tick();
        check_eq("slow_busy_cycles", busy_s_cnt, 3*10*CPB_S);
        check_eq("slow_edge_count", slow_edges, 11);
        check_eq("slow_misaligned_edges", slow_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
